// File: rtl/imem_loader_if.sv
// Byte-stream load port and CPU fetch port of the instruction-memory loader.
interface imem_loader_if #(
    parameter int unsigned AW = 8
);
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          reload;
    logic [AW-1:0] rom_addr;
    logic [31:0]   instr;
    logic          cpu_rst_n;
    logic          load_done;
    logic [AW:0]   word_cnt;

    modport master (
        output ld_valid, ld_data, ld_last, reload, rom_addr,
        input  ld_ready, instr, cpu_rst_n, load_done, word_cnt
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, reload, rom_addr,
        output ld_ready, instr, cpu_rst_n, load_done, word_cnt
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loaded little-endian from a byte stream; holds the CPU
// in reset until an image is complete, then serves fetches.
module imem_loader #(
    parameter int unsigned AW  = 8,
    parameter logic [31:0] NOP = 32'h00000013
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

    state_e        state_q, state_d;
    logic [1:0]    lane_q, lane_d;
    logic [23:0]   buf_q, buf_d;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    logic          ld_ready_q, ld_ready_d;
    logic          cpu_rst_n_q, cpu_rst_n_d;
    logic          load_done_q, load_done_d;

    logic [31:0]   mem_q [DEPTH];
    logic          accept;
    logic          mem_we;
    logic [31:0]   word_c;

    assign accept = bus.ld_valid && ld_ready_q;

    // Lanes not yet received are zero, so a short final word is zero-filled.
    always_comb begin
        word_c = 32'd0;
        case (lane_q)
            2'd0:    word_c = {24'd0, bus.ld_data};
            2'd1:    word_c = {16'd0, bus.ld_data, buf_q[7:0]};
            2'd2:    word_c = {8'd0, bus.ld_data, buf_q[15:0]};
            default: word_c = {bus.ld_data, buf_q};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        buf_d       = buf_q;
        word_cnt_d  = word_cnt_q;
        ld_ready_d  = ld_ready_q;
        cpu_rst_n_d = cpu_rst_n_q;
        load_done_d = load_done_q;
        mem_we      = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    state_d = LOAD;
                    lane_d  = lane_q + 2'd1;
                    case (lane_q)
                        2'd0:    buf_d[7:0]   = bus.ld_data;
                        2'd1:    buf_d[15:8]  = bus.ld_data;
                        2'd2:    buf_d[23:16] = bus.ld_data;
                        default: buf_d        = buf_q;
                    endcase
                    if (lane_q == 2'd3 || bus.ld_last) begin
                        mem_we     = 1'b1;
                        lane_d     = 2'd0;
                        word_cnt_d = word_cnt_q + CW'(1);
                    end
                    // End of image, or memory full: release the CPU.
                    if (bus.ld_last || word_cnt_d == CW'(DEPTH)) begin
                        state_d     = RUN;
                        ld_ready_d  = 1'b0;
                        cpu_rst_n_d = 1'b1;
                        load_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.reload) begin
                    state_d     = IDLE;
                    lane_d      = 2'd0;
                    word_cnt_d  = '0;
                    ld_ready_d  = 1'b1;
                    cpu_rst_n_d = 1'b0;
                    load_done_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lane_q      <= 2'd0;
            buf_q       <= 24'd0;
            word_cnt_q  <= '0;
            ld_ready_q  <= 1'b1;
            cpu_rst_n_q <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            buf_q       <= buf_d;
            word_cnt_q  <= word_cnt_d;
            ld_ready_q  <= ld_ready_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            load_done_q <= load_done_d;
        end
    end

    // Memory contents survive reset and reload.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[word_cnt_q[AW-1:0]] <= word_c;
        end
    end

    assign bus.instr     = (state_q == RUN) ? mem_q[bus.rom_addr] : NOP;
    assign bus.ld_ready  = ld_ready_q;
    assign bus.cpu_rst_n = cpu_rst_n_q;
    assign bus.load_done = load_done_q;
    assign bus.word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-image model.
module tb_imem_loader;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [31:0] model_mem [DEPTH];
    logic [7:0]  img [$];

    imem_loader_if #(.AW(AW)) bus ();

    imem_loader #(.AW(AW), .NOP(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: each word is filled in arrival order, unreceived bytes zero.
    function automatic int model_load();
        int n;
        n = img.size();
        for (int i = 0; i < n; i++) begin
            if (i / 4 < int'(DEPTH)) begin
                if (i % 4 == 0) model_mem[i/4] = 32'd0;
                model_mem[i/4][8*(i%4) +: 8] = img[i];
            end
        end
        return ((n + 3) / 4 > int'(DEPTH)) ? int'(DEPTH) : (n + 3) / 4;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit last, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_data  = b;
        bus.ld_last  = last;
        bus.reload   = 1'($urandom_range(0, 1));
        check("instr_nop_load", bus.instr, NOP);
        n = 0;
        while (!bus.ld_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ld_ready) check("ld_ready_timeout", 32'(bus.ld_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        bus.reload   = 1'b0;
    endtask

    task automatic load_image(input bit with_last, input int max_gap);
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], with_last && (i == img.size() - 1), $urandom_range(0, max_gap));
            if (i < img.size() - 1) begin
                check("load_done_mid", 32'(bus.load_done), 32'd0);
                check("cpu_rst_n_mid", 32'(bus.cpu_rst_n), 32'd0);
            end
        end
    endtask

    task automatic check_run(input int exp_cnt);
        check("run_load_done", 32'(bus.load_done), 32'd1);
        check("run_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
        check("run_ld_ready", 32'(bus.ld_ready), 32'd0);
        check("run_word_cnt", 32'(bus.word_cnt), 32'(exp_cnt));
        for (int a = 0; a < int'(DEPTH); a++) begin
            bus.rom_addr = AW'(a);
            #1;
            check("run_instr", bus.instr, model_mem[a]);
        end
    endtask

    // Reload pulse with a byte offered alongside it; that byte must be dropped.
    task automatic go_idle();
        @(negedge clk);
        bus.reload   = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h5a;
        @(posedge clk);
        #1;
        bus.reload   = 1'b0;
        bus.ld_valid = 1'b0;
        check("idle_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("idle_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        check("idle_load_done", 32'(bus.load_done), 32'd0);
        check("idle_word_cnt", 32'(bus.word_cnt), 32'd0);
        check("idle_instr", bus.instr, NOP);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int n;
        bit wl;
        tests = 0;
        fails = 0;
        rst = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'd0;
        bus.ld_last  = 1'b0;
        bus.reload   = 1'b0;
        bus.rom_addr = '0;
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'd0;

        #1 rst = 1'b1;
        #1;
        check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        check("rst_load_done", 32'(bus.load_done), 32'd0);
        check("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
        check("rst_instr", bus.instr, NOP);
        @(posedge clk);
        #1 rst = 1'b0;

        // Two full words.
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        cnt = model_load();
        load_image(1'b1, 0);
        check_run(cnt);
        bus.rom_addr = AW'(1);
        #1 check("full_word_mem1", bus.instr, 32'h00100093);
        bus.rom_addr = AW'(0);
        #1 check("full_word_mem0", bus.instr, 32'h00000013);

        // Asynchronous reset while running.
        #1 rst = 1'b1;
        #1;
        check("arst_run_load_done", 32'(bus.load_done), 32'd0);
        check("arst_run_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        check("arst_run_word_cnt", 32'(bus.word_cnt), 32'd0);
        check("arst_run_ld_ready", 32'(bus.ld_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Partial final word.
        img = '{8'haa, 8'hbb, 8'hcc};
        cnt = model_load();
        load_image(1'b1, 1);
        check_run(cnt);
        bus.rom_addr = AW'(0);
        #1 check("partial_mem0", bus.instr, 32'h00ccbbaa);

        // Fill to capacity with gaps, then a 17th byte.
        go_idle();
        img = {};
        for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
        cnt = model_load();
        load_image(1'b0, 2);
        check_run(cnt);
        @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'hff;
        check("fill_ld_ready", 32'(bus.ld_ready), 32'd0);
        @(posedge clk);
        #1 bus.ld_valid = 1'b0;
        check_run(cnt);

        // Reload and a one-word image; other words retained.
        go_idle();
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        cnt = model_load();
        load_image(1'b1, 1);
        check_run(cnt);

        // Asynchronous reset two bytes into the second word.
        go_idle();
        img = {};
        for (int i = 0; i < 6; i++) img.push_back(8'($urandom));
        load_image(1'b0, 0);
        check("arst_pre_word_cnt", 32'(bus.word_cnt), 32'd1);
        img = img[0:3];
        void'(model_load());
        #2 rst = 1'b1;
        #1;
        check("arst_load_word_cnt", 32'(bus.word_cnt), 32'd0);
        check("arst_load_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        check("arst_load_ld_ready", 32'(bus.ld_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        img = '{8'hde, 8'had, 8'hbe, 8'hef};
        cnt = model_load();
        load_image(1'b1, 0);
        check_run(cnt);

        // Random images.
        for (int t = 0; t < 12; t++) begin
            go_idle();
            n  = $urandom_range(1, 16);
            wl = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            img = {};
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            cnt = model_load();
            load_image(wl, 3);
            check_run(cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
